kcpsm_io_mailbox: RTL and testbench

Port-mapped I/O peripheral on the kcpsmx processor port bus (port_id / read_strobe / write_strobe / out_port / in_port / interrupt / interrupt_ack).
- Consumes OUTPUT instructions into a TX FIFO that drains to a downstream ready/valid consumer.
- Feeds INPUT instructions from an RX FIFO filled by an upstream ready/valid producer.
- Raises the processor interrupt when RX data arrives.
- Sits directly beside the processor core in the system top and in the program-level benches.

---
 rtl/kcpsmx3_inc.sv | 47 ++++
 rtl/mailbox_sync_fifo.sv | 66 ++++++
 rtl/kcpsm_io_mailbox.sv | 157 +++++++++++++++
 tb/tb_kcpsm_io_mailbox.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx3_inc.sv
// ---------------------------------------------------------------------------
// kcpsmx3_inc - shared definitions for the kcpsmx3 processor and its port-bus
// peripherals.
//
// Contents:
//   OPERAND_WIDTH        width of processor operands and port-bus data/address
//   MBX_DATA_OFS/CTRL_OFS  register offsets of the I/O mailbox from its base
//   MBX_STAT_*           bit indices of the mailbox STATUS register
//   MBX_CTRL_*           bit indices of the mailbox CTRL register
//   mbx_status_t         packed STATUS layout, bit 7 first
// ---------------------------------------------------------------------------
package kcpsmx3_inc;

  localparam int OPERAND_WIDTH = 8;

  // Mailbox register map (offsets from BASE_ADDR)
  localparam int MBX_DATA_OFS = 0;
  localparam int MBX_CTRL_OFS = 1;

  // Mailbox STATUS bit indices
  localparam int MBX_STAT_TX_EMPTY    = 0;
  localparam int MBX_STAT_TX_FULL     = 1;
  localparam int MBX_STAT_RX_EMPTY    = 2;
  localparam int MBX_STAT_RX_FULL     = 3;
  localparam int MBX_STAT_IRQ_PENDING = 4;
  localparam int MBX_STAT_TX_OVF      = 5;
  localparam int MBX_STAT_RX_UDF      = 6;
  localparam int MBX_STAT_IRQ_EN      = 7;

  // Mailbox CTRL bit indices (bits 7:4 are ignored)
  localparam int MBX_CTRL_IRQ_EN     = 0;
  localparam int MBX_CTRL_FLUSH_TX   = 1;
  localparam int MBX_CTRL_FLUSH_RX   = 2;
  localparam int MBX_CTRL_CLR_STICKY = 3;

  typedef struct packed {
    logic irq_en;
    logic rx_udf;
    logic tx_ovf;
    logic irq_pending;
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } mbx_status_t;

endpackage

// File: rtl/mailbox_sync_fifo.sv
// ---------------------------------------------------------------------------
// mailbox_sync_fifo - single-clock first-word-fall-through FIFO used for both
// directions of the I/O mailbox.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, wdata  write request and data (ignored when full)
//   pop          read request (ignored when empty)
//   flush        empties the FIFO; wins over push/pop on the same edge
//   head         current head word (valid when !empty)
//   empty, full  occupancy flags, evaluated before the edge
//
// Pointers carry one extra wrap bit so that full and empty are distinguished
// without a separate count; DEPTH must be a power of 2, minimum 2.
// ---------------------------------------------------------------------------
module mailbox_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/kcpsm_io_mailbox.sv
// ---------------------------------------------------------------------------
// kcpsm_io_mailbox - port-mapped I/O mailbox for the kcpsmx processor bus.
//
// OUTPUT to DATA pushes into the TX FIFO, which drains to a ready/valid
// consumer. INPUT from DATA pops the RX FIFO, which is filled by a ready/valid
// producer. STATUS/CTRL sits at BASE_ADDR+1.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   port_id, read_strobe, write_strobe processor port-bus controls
//   out_port / in_port                 processor write / read data
//   interrupt, interrupt_ack           RX-arrival interrupt and its ack
//   tx_data, tx_valid, tx_ready        downstream (TX) ready/valid side
//   rx_data, rx_valid, rx_ready        upstream (RX) ready/valid side
//
// Build option: define MAILBOX_IRQ_EN to include the interrupt logic; without
// it interrupt is tied low, irq_en/irq_pending read 0, CTRL bit 0 and
// interrupt_ack are ignored.
// ---------------------------------------------------------------------------
module kcpsm_io_mailbox
  import kcpsmx3_inc::*;
#(
  parameter logic [OPERAND_WIDTH-1:0] BASE_ADDR = 8'h10,
  parameter int                       DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPERAND_WIDTH-1:0] port_id,
  input  logic                     read_strobe,
  input  logic                     write_strobe,
  input  logic [OPERAND_WIDTH-1:0] out_port,
  output logic [OPERAND_WIDTH-1:0] in_port,
  output logic                     interrupt,
  input  logic                     interrupt_ack,
  output logic [OPERAND_WIDTH-1:0] tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [OPERAND_WIDTH-1:0] rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready
);

  localparam logic [OPERAND_WIDTH-1:0] DATA_ADDR = BASE_ADDR + OPERAND_WIDTH'(MBX_DATA_OFS);
  localparam logic [OPERAND_WIDTH-1:0] CTRL_ADDR = BASE_ADDR + OPERAND_WIDTH'(MBX_CTRL_OFS);

  logic data_sel, ctrl_sel, ctrl_wr;
  logic tx_push, tx_flush, tx_empty, tx_full;
  logic rx_pop, rx_push, rx_flush, rx_empty, rx_full;
  logic [OPERAND_WIDTH-1:0] rx_head;
  logic tx_ovf, rx_udf;
  logic irq_en, irq_pending;
  mbx_status_t status;

  assign data_sel = (port_id == DATA_ADDR);
  assign ctrl_sel = (port_id == CTRL_ADDR);
  assign ctrl_wr  = write_strobe && ctrl_sel;

  assign tx_push  = write_strobe && data_sel;
  assign tx_flush = ctrl_wr && out_port[MBX_CTRL_FLUSH_TX];
  assign rx_pop   = read_strobe && data_sel;
  assign rx_flush = ctrl_wr && out_port[MBX_CTRL_FLUSH_RX];
  // An RX word is only accepted when there is room and no flush this edge.
  assign rx_push  = rx_valid && !rx_full && !rx_flush;

  mailbox_sync_fifo #(.WIDTH(OPERAND_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_valid && tx_ready),
    .flush (tx_flush),
    .wdata (out_port),
    .head  (tx_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

  mailbox_sync_fifo #(.WIDTH(OPERAND_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (rx_data),
    .head  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // Sticky error flags. The set terms come after the clear so a new error on
  // the same edge as a clear is not lost. Flushes never count as errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (ctrl_wr && out_port[MBX_CTRL_CLR_STICKY]) begin
        tx_ovf <= 1'b0;
        rx_udf <= 1'b0;
      end
      if (tx_push && tx_full && !tx_flush) tx_ovf <= 1'b1;
      if (rx_pop && rx_empty && !rx_flush) rx_udf <= 1'b1;
    end
  end

`ifdef MAILBOX_IRQ_EN
  logic irq_en_q, irq_pending_q;

  // A push beats an ack on the same edge so an arrival is never missed.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= out_port[MBX_CTRL_IRQ_EN];
      if (rx_push && irq_en_q)  irq_pending_q <= 1'b1;
      else if (interrupt_ack)   irq_pending_q <= 1'b0;
    end
  end

  assign irq_en      = irq_en_q;
  assign irq_pending = irq_pending_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = interrupt_ack;
  assign irq_en         = 1'b0;
  assign irq_pending    = 1'b0;
`endif

  assign interrupt = irq_pending;

  always_comb begin
    status             = '0;
    status.irq_en      = irq_en;
    status.rx_udf      = rx_udf;
    status.tx_ovf      = tx_ovf;
    status.irq_pending = irq_pending;
    status.rx_full     = rx_full;
    status.rx_empty    = rx_empty;
    status.tx_full     = tx_full;
    status.tx_empty    = tx_empty;
  end

  // NOTE: in_port gets a default before the decode so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    in_port = '0;
    if (data_sel) begin
      in_port = rx_empty ? '0 : rx_head;
    end else if (ctrl_sel) begin
      in_port = status;
    end
  end

endmodule

// File: tb/tb_kcpsm_io_mailbox.sv
// ---------------------------------------------------------------------------
// tb_kcpsm_io_mailbox - directed bench for kcpsm_io_mailbox (BASE_ADDR=8'h10,
// DEPTH=16). Expectations for interrupt-related bits follow MAILBOX_IRQ_EN.
// ---------------------------------------------------------------------------
module tb_kcpsm_io_mailbox;

  localparam logic [7:0] DATA = 8'h10;
  localparam logic [7:0] STAT = 8'h11;

`ifdef MAILBOX_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  localparam logic [7:0] IE = IRQ ? 8'h80 : 8'h00;  // STATUS irq_en
  localparam logic [7:0] IP = IRQ ? 8'h10 : 8'h00;  // STATUS irq_pending

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = '0;
  logic       read_strobe = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = '0;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;

  int total = 0;
  int bad   = 0;

  kcpsm_io_mailbox #(.BASE_ADDR(8'h10), .DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id = addr;
    #1;
    check(tag, in_port, exp);
  endtask

  // INPUT from DATA: check the combinational read value, then pop on the edge.
  task automatic in_rd(input string tag, input logic [7:0] exp);
    port_id = DATA;
    #1;
    check(tag, in_port, exp);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset state, during reset and on the cycle after release.
    repeat (2) tick();
    peek("rst_status", STAT, 8'h05);
    check("rst_tx_valid", 8'(tx_valid), 8'h00);
    check("rst_rx_ready", 8'(rx_ready), 8'h01);
    check("rst_interrupt", 8'(interrupt), 8'h00);
    reset = 1'b0;
    tick();
    peek("post_rst_status", STAT, 8'h05);
    peek("post_rst_data", DATA, 8'h00);

    // 2. Three words held back, then drained on consecutive cycles.
    out_wr(DATA, 8'hA1);
    check("tx_latency_valid", 8'(tx_valid), 8'h01);
    check("tx_latency_data", tx_data, 8'hA1);
    out_wr(DATA, 8'hB2);
    out_wr(DATA, 8'hC3);
    peek("tx3_status", STAT, 8'h04);
    tx_ready = 1'b1;
    check("tx_drain_a1", tx_data, 8'hA1);
    tick();
    check("tx_drain_b2", tx_data, 8'hB2);
    tick();
    check("tx_drain_c3", tx_data, 8'hC3);
    tick();
    check("tx_drained", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;

    // 3. Seventeen writes into 16 entries: last one dropped, tx_ovf set.
    //    RX is still empty, so STATUS = tx_ovf|rx_empty|tx_full = 8'h26.
    for (int i = 0; i < 17; i++) out_wr(DATA, 8'(8'h30 + i));
    peek("tx_ovf_status", STAT, 8'h26);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_full_drain_%0d", i), tx_data, 8'(8'h30 + i));
      tick();
    end
    check("tx_full_drained", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;
    out_wr(STAT, 8'h08);
    peek("clr_sticky_status", STAT, 8'h05);

    // 4. Interrupt on RX arrival, pop, ack, then underflow.
    out_wr(STAT, 8'h01);
    peek("irq_en_status", STAT, 8'h05 | IE);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("irq_rise", 8'(interrupt), 8'(IRQ));
    peek("rx1_status", STAT, 8'h01 | IE | IP);
    in_rd("rx_pop_5a", 8'h5A);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_ack_clear", 8'(interrupt), 8'h00);
    in_rd("rx_empty_read", 8'h00);
    peek("rx_udf_status", STAT, 8'h45 | IE);
    out_wr(STAT, 8'h09);
    peek("clr_udf_status", STAT, 8'h05 | IE);

    // 5. Push and ack on the same edge keep the interrupt; irq_en=0 blocks it.
    rx_data       = 8'h77;
    rx_valid      = 1'b1;
    interrupt_ack = 1'b1;
    tick();
    rx_valid      = 1'b0;
    interrupt_ack = 1'b0;
    check("push_ack_same_edge", 8'(interrupt), 8'(IRQ));
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_ack_clear2", 8'(interrupt), 8'h00);
    in_rd("rx_pop_77", 8'h77);
    out_wr(STAT, 8'h00);
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("irq_disabled", 8'(interrupt), 8'h00);
    in_rd("rx_pop_66", 8'h66);

    // 6. Fill RX, push+pop while full (push dropped), flush alongside a push.
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h40 + i);
      tick();
    end
    rx_valid = 1'b0;
    check("rx_full_ready", 8'(rx_ready), 8'h00);
    peek("rx_full_status", STAT, 8'h09);
    peek("rx_full_head", DATA, 8'h40);
    rx_data     = 8'hEE;
    rx_valid    = 1'b1;
    read_strobe = 1'b1;
    tick();
    rx_valid    = 1'b0;
    read_strobe = 1'b0;
    check("rx_full_push_drop", 8'(rx_ready), 8'h01);
    peek("rx_head_after_pop", DATA, 8'h41);
    rx_data  = 8'hDD;
    rx_valid = 1'b1;
    out_wr(STAT, 8'h04);
    rx_valid = 1'b0;
    peek("rx_flush_status", STAT, 8'h05);
    peek("rx_flush_data", DATA, 8'h00);

    // Reset with TX half full; strobes during reset are ignored.
    for (int i = 0; i < 8; i++) out_wr(DATA, 8'(8'h90 + i));
    check("tx_half_valid", 8'(tx_valid), 8'h01);
    reset        = 1'b1;
    port_id      = DATA;
    out_port     = 8'hFF;
    write_strobe = 1'b1;
    rx_valid     = 1'b1;
    tick();
    write_strobe = 1'b0;
    rx_valid     = 1'b0;
    check("rst_mid_tx_valid", 8'(tx_valid), 8'h00);
    reset = 1'b0;
    tick();
    peek("rst_mid_status", STAT, 8'h05);
    check("rst_mid_tx_valid2", 8'(tx_valid), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
